// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        STEP  = 2'd3
    } arb_state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Per-access wait counter; expired flags that the access has waited WAIT_MAX cycles.
module wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises each pipeline step into an optional data access then one fetch on a
// shared single-port memory, holding the datapath until both have completed.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              hold,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] i_addr_q, d_addr_q;
    logic [DATA_W-1:0] d_wdata_q, i_rdata_q, d_rdata_q;
    logic              d_we_q, err_q;

    logic in_access, cur_misaligned, expired, abort, issue, done, tmr_clr, tmr_inc;

    // An access that is misaligned or has timed out spends one cycle with no request.
    always_comb begin
        in_access      = (state_q == DATA) || (state_q == FETCH);
        cur_misaligned = (state_q == DATA) ? is_misaligned(d_addr_q[1:0])
                                           : is_misaligned(i_addr_q[1:0]);
        abort          = in_access && (cur_misaligned || expired);
        issue          = in_access && !abort;
        done           = abort || (issue && mem_ready);
        tmr_inc        = issue && !mem_ready;
        tmr_clr        = !in_access || done;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = d_req ? DATA : FETCH;
            DATA:    if (done) state_d = FETCH;
            FETCH:   if (done) state_d = STEP;
            default: state_d = IDLE;
        endcase
    end

    wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            d_we_q    <= 1'b0;
            d_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                i_addr_q  <= i_addr;
                d_addr_q  <= d_addr;
                d_we_q    <= d_we;
                d_wdata_q <= d_wdata;
            end
            // A completed store leaves load data alone; a failed access always zeroes it.
            if (state_q == DATA && done && (abort || !d_we_q)) begin
                d_rdata_q <= abort ? '0 : mem_rdata;
            end
            if (state_q == FETCH && done) begin
                i_rdata_q <= abort ? '0 : mem_rdata;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign hold      = (state_q != STEP);
    assign err       = err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = issue;
    assign mem_we    = issue && (state_q == DATA) && d_we_q;
    assign mem_addr  = (state_q == DATA) ? d_addr_q : i_addr_q;
    assign mem_wdata = d_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port and data port. It sits between the five-stage datapath and the memory, serialises each pipeline step into at most one data access followed by one fetch, and freezes the datapath with `hold` until both complete. It also detects misaligned and timed-out accesses.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, word width.
- `WAIT_MAX`, 15, maximum wait cycles per memory access before timeout (≥1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `i_addr`  in  ADDR_W  fetch byte address from datapath.
- `d_req`  in  1  datapath requests a data access this step.
- `d_we`  in  1  data access is a store (valid with `d_req`).
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `i_rdata`  out  DATA_W  fetched instruction, registered.
- `d_rdata`  out  DATA_W  load data, registered.
- `hold`  out  1  1 = datapath must not advance its pipeline registers.
- `err`  out  1  sticky: misaligned access or timeout seen since reset.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory byte address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ready`=1.

## Operation
- FSM states: IDLE, DATA, FETCH, STEP.
- IDLE:
  - Latch `i_addr`, `d_req`, `d_we`, `d_addr` and `d_wdata` into internal registers.
  - Go to DATA if `d_req`=1, else go to FETCH.
- DATA: drive `mem_req`=1 with the latched data address, write enable and write data.
  - On `mem_ready`: a load captures `mem_rdata` into `d_rdata`; a store leaves `d_rdata` unchanged.
  - Then go to FETCH.
- FETCH: drive `mem_req`=1, `mem_we`=0 and the latched fetch address.
  - On `mem_ready`: capture `mem_rdata` into `i_rdata`, then go to STEP.
- STEP: `hold`=0 for exactly this cycle, so the datapath advances once. Next state is IDLE.
- `hold`=1 in IDLE, DATA and FETCH.
- Data access always precedes fetch within a step.
- Misalignment: an address with bits [1:0]≠0 is not issued to memory.
  - The state spends one cycle with `mem_req`=0, the corresponding rdata register loads 0, `err` is set, and the FSM proceeds as if the access completed.
  - A misaligned store writes nothing.
- Timeout: a per-access wait counter clears on entering DATA or FETCH and increments each cycle that `mem_req`=1 and `mem_ready`=0.
  - When the counter reaches `WAIT_MAX`, the access aborts: `mem_req` drops the next cycle, rdata loads 0, `err` is set, and the FSM proceeds.
- `err` clears only on reset.
- In DATA and FETCH, memory-side outputs come from latched registers only, so they are stable for the whole request.
- In IDLE and STEP, `mem_req`=0 and `mem_we`=0.

## Timing
- Reset values:
  - state = IDLE.
  - `hold`=1, `mem_req`=0, `mem_we`=0, `err`=0.
  - `i_rdata`=0, `d_rdata`=0, `mem_addr`=0, `mem_wdata`=0.
- Handshake: a request completes on the first cycle where `mem_req`=1 and `mem_ready`=1. Data captured at that clock edge is visible on the next cycle.
- A `mem_ready` pulse while `mem_req`=0 is ignored.
- Step length with zero-wait memory (ready in the first request cycle):
  - 3 cycles without a data access (IDLE, FETCH, STEP).
  - 4 cycles with a data access.
- Each wait cycle adds one cycle.
- Worst case per access: `WAIT_MAX`+1 cycles.
- Reset asserted mid-access drops `mem_req` asynchronously and restarts at IDLE. The memory must tolerate an abandoned request.

## Structure
- Shared package `arb_pkg`:
  - state enum `arb_state_t` {IDLE, DATA, FETCH, STEP}.
  - alignment-check function.
- Sub-module `wait_timer`: counter with `clr`, `inc` and `expired` signals, parameterised by `WAIT_MAX`. One instance, reused for both DATA and FETCH.

## Test plan
- Fetch-only step, zero-wait memory: `i_addr`=0x40, `mem_rdata`=0x2002000A → `hold` low on cycle 3 only, `i_rdata`=0x2002000A, `mem_we`=0 throughout.
- Load plus fetch: `d_req`=1, `d_we`=0, `d_addr`=0x100, memory returns 0xDEADBEEF then 0x8C010000 → DATA precedes FETCH, `d_rdata`=0xDEADBEEF, `i_rdata`=0x8C010000, step length 4.
- Store with 2 wait cycles: `d_addr`=0x104, `d_wdata`=0x12345678 → `mem_we`=1 and `mem_addr`/`mem_wdata` stable for 3 cycles, step length 6, `d_rdata` unchanged.
- Misaligned load at `d_addr`=0x102 → no `mem_req` during DATA, `d_rdata`=0, `err`=1, fetch still completes.
- Timeout with `WAIT_MAX`=15 and `mem_ready` never asserted during FETCH → `mem_req` high for 15 cycles, then `i_rdata`=0, `err`=1, STEP occurs.
- Reset pulse during a DATA wait cycle → `mem_req`=0 and `hold`=1 immediately, all outputs at reset values, normal operation resumes from IDLE.
